cpu_mem_responder: RTL and testbench
====================================

// Module: cpu_mem_responder
// PURPOSE
//  Target side of the CPU's 8-bit memory bus: decodes the CPU's address/data phases, serves
//  ROM or RAM bytes on the CPU's data_in with 1-cycle latency, and accepts RAM writes.
//  Also owns a boot loader that fills ROM from a byte stream while holding the CPU in reset.
//  Sits between the cpu core and the chip-level programming pins.
// PARAMETERS
//  BITS       8   bus/data width
//  ROM_DEPTH  32  ROM bytes (power of 2); index = addr mod ROM_DEPTH
//  RAM_DEPTH  16  RAM bytes (power of 2); index = addr mod RAM_DEPTH
// PORTS
//  clk         in   1     clock
//  reset       in   1     synchronous, active-high
//  bus_in      in   BITS  byte driven by CPU (its data_out)
//  rom_ram     in   1     0 = ROM (FETCH_ROM), 1 = RAM (FETCH_RAM)
//  addr_data   in   1     0 = address phase, 1 = data (write) phase
//  data_in     out  BITS  read data to CPU
//  cpu_hold    out  1     OR'd into CPU reset while loading
//  prog_data   in   BITS  boot byte
//  prog_valid  in   1     boot byte valid
//  prog_last   in   1     qualifies final boot byte
//  prog_ready  out  1     loader accepts byte this cycle
//  rom_wr_err  out  1     sticky: data-phase write attempted to ROM
// BEHAVIOUR
//  - Reset: state=LOAD, load_ptr=0, addr_q=0, data_in=0, cpu_hold=1, prog_ready=0 for reset
//    cycle then 1 in LOAD, rom_wr_err=0. RAM cleared to 0; ROM contents not reset.
//  - FSM LOAD: prog_ready=1; prog_valid&prog_ready -> rom[load_ptr]<=prog_data, load_ptr++.
//    Byte with prog_last=1, or byte written at load_ptr=ROM_DEPTH-1 -> RUN next cycle.
//    Bus ignored; data_in held 0.
//  - FSM RUN: cpu_hold=0, prog_ready=0, prog_valid ignored. Leaves only via reset.
//  - Reset mid-load restarts at load_ptr=0; already-written ROM bytes stay until overwritten.
//  - Address phase (addr_data=0): addr_q<=bus_in, sel_q<=rom_ram; next cycle
//    data_in = mem[rom_ram][bus_in]. CPU holding addr_data=0 gets data_in tracking its
//    address with exactly 1 cycle lag.
//  - Data phase (addr_data=1): rom_ram=RAM -> ram[addr_q]<=bus_in, addr_q<=addr_q+1 (8-bit
//    wrap 255->0); next cycle data_in = ram[addr_q+1] (new post-write contents).
//    rom_ram=ROM -> no write, rom_wr_err<=1, addr_q unchanged, data_in = rom[addr_q].
//  - Read-during-write same RAM index returns newly written byte.
//  - rom_ram switching between phases: data phase always uses current rom_ram, not sel_q.
//  - Index truncation: ROM uses addr[log2(ROM_DEPTH)-1:0], RAM addr[log2(RAM_DEPTH)-1:0].
// STRUCTURE
//  - Shared package/include cpu_defs: BITS, FETCH_ROM/FETCH_RAM, PHASE_ADDR=0/PHASE_DATA=1,
//    responder state encodings LOAD/RUN.
//  - One sub-module byte_mem (DEPTH param, sync write, comb read, optional clear-on-reset),
//    instantiated twice (ROM, RAM). FSM, addr_q, data_in register live in top.
// TESTING
//  - Boot: reset, stream 0x11,0x22,0x33 (last on 0x33) -> prog_ready 3 cycles, cpu_hold
//    falls cycle after 0x33, rom[0..2]=11,22,33.
//  - Full load: 32 bytes, no prog_last -> RUN after 32nd; 33rd prog_valid ignored.
//  - ROM read: RUN, addr phase bus_in=0x21, rom_ram=0 -> next-cycle data_in = rom[1] = 0x22.
//  - RAM write+incr: addr 0x0F RAM, data 0xA5, data 0x5A -> ram[15]=A5, ram[0]=5A (wrap),
//    data_in=0x5A; addr 0xFF then data -> addr_q wraps to 0x00.
//  - ROM write attempt: data phase rom_ram=0 -> rom unchanged, rom_wr_err=1 until reset.
//  - Reset mid-load after 2 bytes -> load_ptr=0, next byte lands at rom[0], cpu_hold stays 1.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the CPU memory bus: data width, fetch select and
// phase encodings, and the responder's state encoding.
package cpu_defs;
  localparam int BITS = 8;

  localparam logic FETCH_ROM  = 1'b0;
  localparam logic FETCH_RAM  = 1'b1;
  localparam logic PHASE_ADDR = 1'b0;
  localparam logic PHASE_DATA = 1'b1;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/byte_mem.sv
// Byte-wide storage with a synchronous write port and a combinational read port.
// CLEAR=1 zeroes every entry while reset is held; CLEAR=0 leaves contents alone.
module byte_mem
  import cpu_defs::*;
#(
  parameter int DEPTH = 16,
  parameter bit CLEAR = 1'b0,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [BITS-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [BITS-1:0] rdata
);

  logic [BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (CLEAR && reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Target side of the CPU byte bus: serves ROM/RAM reads with one cycle of latency,
// takes RAM writes with address auto-increment, and boot-loads ROM while holding the CPU.
//
// Boot stream handshake: a byte moves when prog_valid and prog_ready are both high on a
// rising clk edge; prog_ready is registered and never depends on prog_valid, and it stays
// low once the final byte has been taken.
module cpu_mem_responder
  import cpu_defs::*;
#(
  parameter int ROM_DEPTH = 32,
  parameter int RAM_DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] bus_in,
  input  logic            rom_ram,
  input  logic            addr_data,
  output logic [BITS-1:0] data_in,
  output logic            cpu_hold,
  input  logic [BITS-1:0] prog_data,
  input  logic            prog_valid,
  input  logic            prog_last,
  output logic            prog_ready,
  output logic            rom_wr_err,
  output logic            state_dbg
);

  localparam int ROM_AW = $clog2(ROM_DEPTH);
  localparam int RAM_AW = $clog2(RAM_DEPTH);

  state_t            state;
  logic [ROM_AW-1:0] load_ptr;
  logic [BITS-1:0]   addr_q;
  logic [BITS-1:0]   addr_inc;

  logic              is_addr;
  logic              prog_fire;
  logic              ram_we;
  logic              ram_fwd;
  logic [ROM_AW-1:0] rom_raddr;
  logic [RAM_AW-1:0] ram_raddr;
  logic [BITS-1:0]   rom_rdata;
  logic [BITS-1:0]   ram_rdata;

  assign is_addr   = (addr_data == PHASE_ADDR);
  assign addr_inc  = addr_q + BITS'(1);
  assign prog_fire = (state == LOAD) && prog_ready && prog_valid && !reset;
  assign ram_we    = (state == RUN) && !is_addr && (rom_ram == FETCH_RAM) && !reset;

  // Data-phase reads look one byte ahead of the write pointer; ROM data phases read in place.
  assign rom_raddr = is_addr ? bus_in[ROM_AW-1:0] : addr_q[ROM_AW-1:0];
  assign ram_raddr = is_addr ? bus_in[RAM_AW-1:0] : addr_inc[RAM_AW-1:0];
  // Only reachable for a single-entry RAM, where the look-ahead aliases the byte being written.
  assign ram_fwd   = (addr_inc[RAM_AW-1:0] == addr_q[RAM_AW-1:0]);

  assign state_dbg = state;

  byte_mem #(.DEPTH(ROM_DEPTH), .CLEAR(1'b0)) u_rom (
    .clk   (clk),
    .reset (reset),
    .we    (prog_fire),
    .waddr (load_ptr),
    .wdata (prog_data),
    .raddr (rom_raddr),
    .rdata (rom_rdata)
  );

  byte_mem #(.DEPTH(RAM_DEPTH), .CLEAR(1'b1)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (addr_q[RAM_AW-1:0]),
    .wdata (bus_in),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      load_ptr   <= '0;
      addr_q     <= '0;
      data_in    <= '0;
      cpu_hold   <= 1'b1;
      prog_ready <= 1'b0;
      rom_wr_err <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          data_in    <= '0;
          prog_ready <= 1'b1;
          if (prog_fire) begin
            load_ptr <= load_ptr + ROM_AW'(1);
            if (prog_last || load_ptr == ROM_AW'(ROM_DEPTH - 1)) begin
              state      <= RUN;
              prog_ready <= 1'b0;
              cpu_hold   <= 1'b0;
            end
          end
        end
        RUN: begin
          cpu_hold   <= 1'b0;
          prog_ready <= 1'b0;
          if (is_addr) begin
            addr_q  <= bus_in;
            data_in <= (rom_ram == FETCH_RAM) ? ram_rdata : rom_rdata;
          end else if (rom_ram == FETCH_RAM) begin
            addr_q  <= addr_inc;
            data_in <= ram_fwd ? bus_in : ram_rdata;
          end else begin
            rom_wr_err <= 1'b1;
            data_in    <= rom_rdata;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: boot loading, ROM/RAM reads, RAM writes with
// address increment and wrap, ROM write errors and reset during loading.
module tb_cpu_mem_responder;

  logic       clk;
  logic       reset;
  logic [7:0] bus_in;
  logic       rom_ram;
  logic       addr_data;
  logic [7:0] data_in;
  logic       cpu_hold;
  logic [7:0] prog_data;
  logic       prog_valid;
  logic       prog_last;
  logic       prog_ready;
  logic       rom_wr_err;
  logic       state_dbg;

  int checks = 0;
  int errors = 0;

  cpu_mem_responder #(.ROM_DEPTH(32), .RAM_DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_in     (bus_in),
    .rom_ram    (rom_ram),
    .addr_data  (addr_data),
    .data_in    (data_in),
    .cpu_hold   (cpu_hold),
    .prog_data  (prog_data),
    .prog_valid (prog_valid),
    .prog_last  (prog_last),
    .prog_ready (prog_ready),
    .rom_wr_err (rom_wr_err),
    .state_dbg  (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    addr_data  = 1'b0;
    rom_ram    = 1'b0;
    bus_in     = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic bus_cycle(input logic sel, input logic phase, input logic [7:0] b);
    rom_ram   = sel;
    addr_data = phase;
    bus_in    = b;
    tick();
    addr_data = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    prog_data  = d;
    prog_valid = 1'b1;
    prog_last  = last;
    tick();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    prog_data  = 8'h00;
    addr_data  = 1'b0;
    rom_ram    = 1'b0;
    bus_in     = 8'h00;
    tick();
    checks++; if (data_in !== 8'h00) begin errors++; $display("FAIL reset_data_in: got %h want 00", data_in); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
    checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL reset_prog_ready: got %b want 0", prog_ready); end
    checks++; if (rom_wr_err !== 1'b0) begin errors++; $display("FAIL reset_rom_wr_err: got %b want 0", rom_wr_err); end
    checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state: got %b want 0", state_dbg); end
    reset = 1'b0;
    tick();
    checks++; if (prog_ready !== 1'b1) begin errors++; $display("FAIL load_prog_ready: got %b want 1", prog_ready); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL load_cpu_hold: got %b want 1", cpu_hold); end
  endtask

  task automatic test_boot();
    logic [7:0] boot_bytes [3];
    boot_bytes = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      checks++; if (prog_ready !== 1'b1) begin errors++; $display("FAIL boot_ready_%0d: got %b want 1", i, prog_ready); end
      checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL boot_hold_%0d: got %b want 1", i, cpu_hold); end
      send_byte(boot_bytes[i], i == 2);
    end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL boot_hold_release: got %b want 0", cpu_hold); end
    checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL boot_ready_drop: got %b want 0", prog_ready); end
    checks++; if (state_dbg !== 1'b1) begin errors++; $display("FAIL boot_state: got %b want 1", state_dbg); end
    for (int i = 0; i < 3; i++) begin
      bus_cycle(1'b0, 1'b0, 8'(i));
      checks++; if (data_in !== boot_bytes[i]) begin errors++; $display("FAIL boot_rom_%0d: got %h want %h", i, data_in, boot_bytes[i]); end
    end
    // Address 0x21 truncates to ROM index 1
    bus_cycle(1'b0, 1'b0, 8'h21);
    checks++; if (data_in !== 8'h22) begin errors++; $display("FAIL rom_read_trunc: got %h want 22", data_in); end
  endtask

  task automatic test_rom_write();
    checks++; if (rom_wr_err !== 1'b0) begin errors++; $display("FAIL rom_err_before: got %b want 0", rom_wr_err); end
    bus_cycle(1'b0, 1'b0, 8'h01);
    checks++; if (data_in !== 8'h22) begin errors++; $display("FAIL rom_wr_addr: got %h want 22", data_in); end
    bus_cycle(1'b0, 1'b1, 8'hFF);
    checks++; if (rom_wr_err !== 1'b1) begin errors++; $display("FAIL rom_err_set: got %b want 1", rom_wr_err); end
    checks++; if (data_in !== 8'h22) begin errors++; $display("FAIL rom_wr_data_in: got %h want 22", data_in); end
    bus_cycle(1'b0, 1'b1, 8'hEE);
    checks++; if (data_in !== 8'h22) begin errors++; $display("FAIL rom_wr_addr_hold: got %h want 22", data_in); end
    bus_cycle(1'b0, 1'b0, 8'h01);
    checks++; if (data_in !== 8'h22) begin errors++; $display("FAIL rom_unchanged: got %h want 22", data_in); end
    // ROM address phase followed by a RAM data phase writes RAM
    bus_cycle(1'b0, 1'b0, 8'h02);
    checks++; if (data_in !== 8'h33) begin errors++; $display("FAIL switch_rom_read: got %h want 33", data_in); end
    bus_cycle(1'b1, 1'b1, 8'h44);
    checks++; if (data_in !== 8'h00) begin errors++; $display("FAIL switch_lookahead: got %h want 00", data_in); end
    bus_cycle(1'b1, 1'b0, 8'h02);
    checks++; if (data_in !== 8'h44) begin errors++; $display("FAIL switch_ram_write: got %h want 44", data_in); end
    bus_cycle(1'b0, 1'b0, 8'h02);
    checks++; if (data_in !== 8'h33) begin errors++; $display("FAIL switch_rom_intact: got %h want 33", data_in); end
    checks++; if (rom_wr_err !== 1'b1) begin errors++; $display("FAIL rom_err_sticky: got %b want 1", rom_wr_err); end
    do_reset();
    checks++; if (rom_wr_err !== 1'b0) begin errors++; $display("FAIL rom_err_cleared: got %b want 0", rom_wr_err); end
  endtask

  task automatic test_mid_load_reset();
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    reset = 1'b1;
    tick();
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL midload_hold: got %b want 1", cpu_hold); end
    checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL midload_ready: got %b want 0", prog_ready); end
    reset = 1'b0;
    tick();
    checks++; if (prog_ready !== 1'b1) begin errors++; $display("FAIL midload_ready_back: got %b want 1", prog_ready); end
    send_byte(8'hB0, 1'b1);
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL midload_release: got %b want 0", cpu_hold); end
    bus_cycle(1'b0, 1'b0, 8'h00);
    checks++; if (data_in !== 8'hB0) begin errors++; $display("FAIL midload_rom0: got %h want b0", data_in); end
    bus_cycle(1'b0, 1'b0, 8'h01);
    checks++; if (data_in !== 8'hA2) begin errors++; $display("FAIL midload_rom1: got %h want a2", data_in); end
  endtask

  task automatic test_full_load();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      checks++; if (prog_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %b want 1", i, prog_ready); end
      send_byte(8'(8'h40 + i), 1'b0);
    end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL full_hold_release: got %b want 0", cpu_hold); end
    checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL full_ready_drop: got %b want 0", prog_ready); end
    send_byte(8'hEE, 1'b0);
    checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL extra_ready: got %b want 0", prog_ready); end
    bus_cycle(1'b0, 1'b0, 8'h00);
    checks++; if (data_in !== 8'h40) begin errors++; $display("FAIL full_rom0: got %h want 40", data_in); end
    bus_cycle(1'b0, 1'b0, 8'h1F);
    checks++; if (data_in !== 8'h5F) begin errors++; $display("FAIL full_rom31: got %h want 5f", data_in); end
    bus_cycle(1'b0, 1'b0, 8'hF0);
    checks++; if (data_in !== 8'h50) begin errors++; $display("FAIL full_rom_trunc: got %h want 50", data_in); end
  endtask

  task automatic test_ram_write();
    bus_cycle(1'b1, 1'b0, 8'h01);
    checks++; if (data_in !== 8'h00) begin errors++; $display("FAIL ram_cleared: got %h want 00", data_in); end
    bus_cycle(1'b1, 1'b1, 8'h77);
    bus_cycle(1'b1, 1'b0, 8'h0F);
    checks++; if (data_in !== 8'h00) begin errors++; $display("FAIL ram15_before: got %h want 00", data_in); end
    bus_cycle(1'b1, 1'b1, 8'hA5);
    checks++; if (data_in !== 8'h00) begin errors++; $display("FAIL ram_next0: got %h want 00", data_in); end
    bus_cycle(1'b1, 1'b1, 8'h5A);
    checks++; if (data_in !== 8'h77) begin errors++; $display("FAIL ram_next1: got %h want 77", data_in); end
    bus_cycle(1'b1, 1'b0, 8'h00);
    checks++; if (data_in !== 8'h5A) begin errors++; $display("FAIL ram0_wrap: got %h want 5a", data_in); end
    bus_cycle(1'b1, 1'b0, 8'h0F);
    checks++; if (data_in !== 8'hA5) begin errors++; $display("FAIL ram15: got %h want a5", data_in); end
    bus_cycle(1'b1, 1'b0, 8'h10);
    checks++; if (data_in !== 8'h5A) begin errors++; $display("FAIL ram_trunc: got %h want 5a", data_in); end
    // Post-write look-ahead returns the byte following the one just written
    bus_cycle(1'b1, 1'b0, 8'h03);
    bus_cycle(1'b1, 1'b1, 8'h33);
    bus_cycle(1'b1, 1'b0, 8'h02);
    bus_cycle(1'b1, 1'b1, 8'h99);
    checks++; if (data_in !== 8'h33) begin errors++; $display("FAIL ram_lookahead: got %h want 33", data_in); end
    // Address register wraps 0xFF -> 0x00
    bus_cycle(1'b1, 1'b0, 8'hFF);
    bus_cycle(1'b1, 1'b1, 8'hC3);
    checks++; if (data_in !== 8'h5A) begin errors++; $display("FAIL addr_wrap_next: got %h want 5a", data_in); end
    bus_cycle(1'b1, 1'b1, 8'h3C);
    checks++; if (data_in !== 8'h77) begin errors++; $display("FAIL addr_wrap_second: got %h want 77", data_in); end
    bus_cycle(1'b1, 1'b0, 8'h00);
    checks++; if (data_in !== 8'h3C) begin errors++; $display("FAIL addr_wrap_ram0: got %h want 3c", data_in); end
    bus_cycle(1'b1, 1'b0, 8'h0F);
    checks++; if (data_in !== 8'hC3) begin errors++; $display("FAIL addr_wrap_ram15: got %h want c3", data_in); end
    checks++; if (rom_wr_err !== 1'b0) begin errors++; $display("FAIL ram_no_err: got %b want 0", rom_wr_err); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_rom_write();
    test_mid_load_reset();
    test_full_load();
    test_ram_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
